// File: rtl/nibble_serial_subtractor16_pkg.sv
// Shared widths and FSM encoding for the nibble-serial subtractor.
package nibble_serial_subtractor16_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int SLICE_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/Ripple_carry_4bit.sv
// Four-bit ripple-carry adder slice: {cout, sum} = a + b + cin.
module Ripple_carry_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];
endmodule

// File: rtl/nibble_serial_subtractor16.sv
// Multi-cycle a - b: one 4-bit ripple slice reused LSB nibble first, valid/ready on both sides.
module nibble_serial_subtractor16
  import nibble_serial_subtractor16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // in_ready is high only in IDLE, out_valid only in DONE, and a result is
  // never drained in the same cycle a new operand pair is accepted.

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_nb;
  logic [SLICE-1:0] slice_s;
  logic             slice_cout;
  logic [WIDTH-1:0] diff_next;

  assign slice_a  = a_q[idx*SLICE +: SLICE];
  assign slice_nb = ~b_q[idx*SLICE +: SLICE];

  Ripple_carry_4bit u_slice (
    .a    (slice_a),
    .b    (slice_nb),
    .cin  (carry),
    .sum  (slice_s),
    .cout (slice_cout)
  );

  // Full diff as it will look after this edge's nibble lands; flags use it.
  always_comb begin
    diff_next = diff;
    diff_next[idx*SLICE +: SLICE] = slice_s;
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            carry <= 1'b1;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          diff  <= diff_next;
          carry <= slice_cout;
          idx   <= idx + IDX_W'(1);
          if (idx == IDX_LAST) begin
            state    <= DONE;
            borrow   <= ~slice_cout;
            overflow <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                        (diff_next[WIDTH-1] != a_q[WIDTH-1]);
            zero     <= (diff_next == '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_subtractor16.sv
// Directed bench for nibble_serial_subtractor16 with hand-computed expectations.
module tb_nibble_serial_subtractor16;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        borrow;
  logic        overflow;
  logic        zero;

  int n_cmp = 0;
  int n_bad = 0;

  nibble_serial_subtractor16 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .overflow  (overflow),
    .zero      (zero)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an operation, wait for acceptance, check latency and the result.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic [15:0] ed, input logic eb, input logic eo, input logic ez);
    int w;
    int lat;
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    check({tag, "_accept_timeout"}, 32'(w < 20), 32'd1);
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_diff"}, 32'(diff), 32'(ed));
    check({tag, "_borrow"}, 32'(borrow), 32'(eb));
    check({tag, "_overflow"}, 32'(overflow), 32'(eo));
    check({tag, "_zero"}, 32'(zero), 32'(ez));
    if (out_ready) begin
      step();
      check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
      check({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    step();
    step();
    rst = 1'b0;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_diff", 32'(diff), 32'd0);
    check("reset_flags", {29'd0, borrow, overflow, zero}, 32'd0);

    // idle without in_valid must stay idle
    step();
    check("idle_hold", 32'(in_ready), 32'd1);

    run_op("t1", 16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 1'b0);
    run_op("t2", 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_op("t3a", 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    run_op("t3b", 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0);
    run_op("t4", 16'hABCD, 16'hABCD, 16'h0000, 1'b0, 1'b0, 1'b1);
    run_op("t4b", 16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0);
    run_op("t4c", 16'h0F0F, 16'hF0F0, 16'h1E1F, 1'b1, 1'b0, 1'b0);

    // backpressure in DONE with new operands pending
    out_ready = 1'b0;
    run_op("t5", 16'h0100, 16'h0001, 16'h00FF, 1'b0, 1'b0, 1'b0);
    a = 16'h2222;
    b = 16'h1111;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_hold_valid", 32'(out_valid), 32'd1);
      check("t5_hold_diff", 32'(diff), 32'h00FF);
      check("t5_hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t5_drained_in_ready", 32'(in_ready), 32'd1);
    check("t5_drained_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    run_op("t5_next", 16'h2222, 16'h1111, 16'h1111, 1'b0, 1'b0, 1'b0);

    // reset after two RUN slices discards the operation
    a = 16'hFFFF;
    b = 16'h0001;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("t6_running", 32'(in_ready), 32'd0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_in_ready", 32'(in_ready), 32'd1);
    check("t6_out_valid", 32'(out_valid), 32'd0);
    check("t6_diff", 32'(diff), 32'd0);
    check("t6_flags", {29'd0, borrow, overflow, zero}, 32'd0);
    run_op("t6_next", 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
